clk_gate_ctrl: RTL and testbench

- Policy controller that generates the enable for the latch-based clock-gating cell in the low-power block.
- Watches activity from the gated domain and drops the enable after a programmable run of idle cycles.
- Restores the enable on a wake request or new activity, then handshakes wake completion back to the requester.
- Runs on the free-running (ungated) clock.

---
 rtl/clk_gate_pkg.sv | 21 ++
 rtl/clk_gate_ctrl_if.sv | 24 ++
 rtl/cg_sat_counter.sv | 29 ++
 rtl/clk_gate_ctrl.sv | 110 +++++++++++
 tb/tb_clk_gate_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and constants for the clock-gating policy controller.
package clk_gate_pkg;

    // Controller states; ACTIVE is the reset state with the clock running.
    typedef enum logic [1:0] {
        CG_ACTIVE = 2'd0,
        CG_GATED  = 2'd1,
        CG_WAKING = 2'd2
    } cg_state_e;

    // Internal counter widths, sized to the largest legal parameter values.
    localparam int IDLE_W = 8;
    localparam int WAKE_W = 4;

    // Legal parameter ranges, enforced at elaboration by the top.
    localparam int IDLE_CYCLES_MIN = 1;
    localparam int IDLE_CYCLES_MAX = 255;
    localparam int WAKE_CYCLES_MIN = 1;
    localparam int WAKE_CYCLES_MAX = 15;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Policy, activity, wake handshake and status signals of the gating controller.
interface clk_gate_ctrl_if #(
    parameter int STAT_W = 16
);
    logic              allow_gate;
    logic              busy_i;
    logic              wake_req;
    logic              wake_ack;
    logic              gate_en;
    logic              gated;
    logic [STAT_W-1:0] gated_cycles;

    // Requester / software side.
    modport master (
        output allow_gate, busy_i, wake_req,
        input  wake_ack, gate_en, gated, gated_cycles
    );

    // Controller side.
    modport slave (
        input  allow_gate, busy_i, wake_req,
        output wake_ack, gate_en, gated, gated_cycles
    );
endinterface

// File: rtl/cg_sat_counter.sv
// Registered up-counter that sticks at all-ones, with synchronous clear.
module cg_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register; clear doubles as the synchronous reset.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gating policy controller: drops gate_en after a run of idle cycles,
// restores it on wake request or activity, and acknowledges wake requests.
// Runs on the free-running clock; every output is a flop.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    clk_gate_ctrl_if.slave       bus
);
    if (IDLE_CYCLES < IDLE_CYCLES_MIN || IDLE_CYCLES > IDLE_CYCLES_MAX) begin : g_bad_idle
        $error("clk_gate_ctrl: IDLE_CYCLES out of range 1..255");
    end
    if (WAKE_CYCLES < WAKE_CYCLES_MIN || WAKE_CYCLES > WAKE_CYCLES_MAX) begin : g_bad_wake
        $error("clk_gate_ctrl: WAKE_CYCLES out of range 1..15");
    end

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    cg_state_e         state_q,    state_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              gate_en_q,  gate_en_d;
    logic              gated_q,    gated_d;
    logic              wake_ack_q, wake_ack_d;
    logic [STAT_W-1:0] gated_cycles;

    logic idle;
    logic wake_cond;
    logic idle_done;

    assign idle      = bus.allow_gate & ~bus.busy_i & ~bus.wake_req;
    assign wake_cond = bus.wake_req | bus.busy_i | ~bus.allow_gate;
    assign idle_done = idle && (idle_cnt_q == IDLE_LAST);

    // State and registered outputs; reset forces the clock back on.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= CG_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            gate_en_q  <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            gate_en_q  <= gate_en_d;
            gated_q    <= gated_d;
            wake_ack_q <= wake_ack_d;
        end
    end

    // Next-state decision.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            CG_ACTIVE: if (idle_done)                state_d = CG_GATED;
            CG_GATED:  if (wake_cond)                state_d = CG_WAKING;
            CG_WAKING: if (wake_cnt_q == WAKE_LAST)  state_d = CG_ACTIVE;
            default:                                 state_d = CG_ACTIVE;
        endcase
    end

    // Next values of counters and registered outputs.
    always_comb begin
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        gate_en_d  = (state_d != CG_GATED);
        gated_d    = (state_d == CG_GATED);
        // Acknowledge only from ACTIVE; a request seen in WAKING waits here.
        wake_ack_d = (state_q == CG_ACTIVE) && bus.wake_req;
        case (state_q)
            CG_ACTIVE: begin
                if (idle && !idle_done) begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            CG_WAKING: begin
                if (state_d == CG_WAKING) begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Statistics: cycles spent in GATED, cleared by reset only.
    cg_sat_counter #(
        .W (STAT_W)
    ) u_gated_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (state_q == CG_GATED),
        .cnt_o (gated_cycles)
    );

    assign bus.gate_en      = gate_en_q;
    assign bus.gated        = gated_q;
    assign bus.wake_ack     = wake_ack_q;
    assign bus.gated_cycles = gated_cycles;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed testbench for clk_gate_ctrl: IDLE_CYCLES=8, WAKE_CYCLES=2, with a
// 16-bit and a 4-bit statistics instance driven by identical stimulus.
module tb_clk_gate_ctrl;
    logic clk;
    logic rst;
    logic allow_gate;
    logic busy_i;
    logic wake_req;

    int checks;
    int failures;

    clk_gate_ctrl_if #(.STAT_W(16)) b16 ();
    clk_gate_ctrl_if #(.STAT_W(4))  b4  ();

    assign b16.allow_gate = allow_gate;
    assign b16.busy_i     = busy_i;
    assign b16.wake_req   = wake_req;
    assign b4.allow_gate  = allow_gate;
    assign b4.busy_i      = busy_i;
    assign b4.wake_req    = wake_req;

    clk_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2), .STAT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    clk_gate_ctrl #(.IDLE_CYCLES(8), .WAKE_CYCLES(2), .STAT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; allow_gate = 1'b0; busy_i = 1'b0; wake_req = 1'b0;
        steps(2);
        checks++;
        if ({b16.gate_en, b16.gated, b16.wake_ack} !== 3'b100) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 100", {b16.gate_en, b16.gated, b16.wake_ack});
        end
        checks++;
        if (b16.gated_cycles !== 16'd0) begin
            failures++;
            $display("FAIL reset_stat: got %0d expected 0", b16.gated_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_gate_entry();
        allow_gate = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (b16.gate_en !== 1'b1) begin
                failures++;
                $display("FAIL entry_idle%0d: gate_en got %b expected 1", i, b16.gate_en);
            end
        end
        step();
        checks++;
        if ({b16.gate_en, b16.gated} !== 2'b01) begin
            failures++;
            $display("FAIL entry_gated: {gate_en,gated} got %b expected 01", {b16.gate_en, b16.gated});
        end
    endtask

    task automatic test_wake_req();
        steps(9);
        wake_req = 1'b1;
        step();
        checks++;
        if ({b16.gate_en, b16.gated, b16.wake_ack} !== 3'b100) begin
            failures++;
            $display("FAIL wake_ungate: got %b expected 100", {b16.gate_en, b16.gated, b16.wake_ack});
        end
        checks++;
        if (b16.gated_cycles !== 16'd10) begin
            failures++;
            $display("FAIL wake_stat: got %0d expected 10", b16.gated_cycles);
        end
        for (int i = 2; i <= 3; i++) begin
            step();
            checks++;
            if ({b16.gate_en, b16.wake_ack} !== 2'b10) begin
                failures++;
                $display("FAIL wake_edge%0d: {gate_en,wake_ack} got %b expected 10", i, {b16.gate_en, b16.wake_ack});
            end
        end
        step();
        checks++;
        if (b16.wake_ack !== 1'b1) begin
            failures++;
            $display("FAIL wake_ack_rise: got %b expected 1", b16.wake_ack);
        end
        wake_req = 1'b0;
        busy_i   = 1'b1;
        step();
        checks++;
        if (b16.wake_ack !== 1'b0) begin
            failures++;
            $display("FAIL wake_ack_fall: got %b expected 0", b16.wake_ack);
        end
        busy_i = 1'b0;
    endtask

    task automatic test_idle_interrupt();
        steps(7);
        checks++;
        if (b16.gate_en !== 1'b1) begin
            failures++;
            $display("FAIL intr_first7: gate_en got %b expected 1", b16.gate_en);
        end
        busy_i = 1'b1;
        step();
        busy_i = 1'b0;
        checks++;
        if (b16.gate_en !== 1'b1) begin
            failures++;
            $display("FAIL intr_busy: gate_en got %b expected 1", b16.gate_en);
        end
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (b16.gate_en !== 1'b1) begin
                failures++;
                $display("FAIL intr_idle%0d: gate_en got %b expected 1", i, b16.gate_en);
            end
        end
        step();
        checks++;
        if ({b16.gate_en, b16.gated} !== 2'b01) begin
            failures++;
            $display("FAIL intr_gated: {gate_en,gated} got %b expected 01", {b16.gate_en, b16.gated});
        end
    endtask

    task automatic test_allow_drop();
        step();
        allow_gate = 1'b0;
        step();
        checks++;
        if ({b16.gate_en, b16.gated} !== 2'b10) begin
            failures++;
            $display("FAIL allow_wake: {gate_en,gated} got %b expected 10", {b16.gate_en, b16.gated});
        end
        checks++;
        if (b16.gated_cycles !== 16'd12) begin
            failures++;
            $display("FAIL allow_stat: got %0d expected 12", b16.gated_cycles);
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (b16.gate_en !== 1'b1) begin
                failures++;
                $display("FAIL allow_low%0d: gate_en got %b expected 1", i, b16.gate_en);
            end
        end
    endtask

    task automatic test_simultaneous();
        allow_gate = 1'b1;
        steps(7);
        wake_req = 1'b1;
        step();
        checks++;
        if ({b16.gate_en, b16.gated, b16.wake_ack} !== 3'b101) begin
            failures++;
            $display("FAIL simul_wake: got %b expected 101", {b16.gate_en, b16.gated, b16.wake_ack});
        end
        wake_req = 1'b0;
        step();
        checks++;
        if ({b16.gate_en, b16.wake_ack} !== 2'b10) begin
            failures++;
            $display("FAIL simul_drop: {gate_en,wake_ack} got %b expected 10", {b16.gate_en, b16.wake_ack});
        end
        steps(6);
        checks++;
        if (b16.gate_en !== 1'b1) begin
            failures++;
            $display("FAIL simul_cleared: gate_en got %b expected 1", b16.gate_en);
        end
        step();
        checks++;
        if (b16.gate_en !== 1'b0) begin
            failures++;
            $display("FAIL simul_regate: gate_en got %b expected 0", b16.gate_en);
        end
        busy_i = 1'b1;
        step();
        busy_i = 1'b0;
        checks++;
        if ({b16.gate_en, b16.gated} !== 2'b10) begin
            failures++;
            $display("FAIL busy_wake: {gate_en,gated} got %b expected 10", {b16.gate_en, b16.gated});
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        allow_gate = 1'b1;
        steps(8);
        checks++;
        if (b16.gated !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_gated: got %b expected 1", b16.gated);
        end
        steps(3);
        rst = 1'b1;
        step();
        checks++;
        if ({b16.gate_en, b16.gated, b16.wake_ack, b16.gated_cycles} !== {3'b100, 16'd0}) begin
            failures++;
            $display("FAIL rst_in_gated: got %b/%0d expected 100/0", {b16.gate_en, b16.gated, b16.wake_ack}, b16.gated_cycles);
        end
        rst = 1'b0;
        steps(8);
        wake_req = 1'b1;
        step();
        checks++;
        if ({b16.gate_en, b16.gated} !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_waking: {gate_en,gated} got %b expected 10", {b16.gate_en, b16.gated});
        end
        rst = 1'b1;
        wake_req = 1'b0;
        step();
        checks++;
        if ({b16.gate_en, b16.gated, b16.wake_ack, b16.gated_cycles} !== {3'b100, 16'd0}) begin
            failures++;
            $display("FAIL rst_in_waking: got %b/%0d expected 100/0", {b16.gate_en, b16.gated, b16.wake_ack}, b16.gated_cycles);
        end
        rst = 1'b0;
        wake_req = 1'b1;
        step();
        checks++;
        if (b16.wake_ack !== 1'b1) begin
            failures++;
            $display("FAIL rst_active: wake_ack got %b expected 1", b16.wake_ack);
        end
        wake_req = 1'b0;
        step();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step();
        rst = 1'b0;
        allow_gate = 1'b1;
        steps(8);
        checks++;
        if ({b16.gated, b4.gated} !== 2'b11) begin
            failures++;
            $display("FAIL sat_gated: got %b expected 11", {b16.gated, b4.gated});
        end
        steps(14);
        checks++;
        if (b4.gated_cycles !== 4'd14) begin
            failures++;
            $display("FAIL sat_w4_14: got %0d expected 14", b4.gated_cycles);
        end
        steps(6);
        checks++;
        if (b4.gated_cycles !== 4'd15) begin
            failures++;
            $display("FAIL sat_w4_20: got %0d expected 15", b4.gated_cycles);
        end
        checks++;
        if (b16.gated_cycles !== 16'd20) begin
            failures++;
            $display("FAIL sat_w16_20: got %0d expected 20", b16.gated_cycles);
        end
        allow_gate = 1'b0;
        steps(4);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_gate_entry();
        test_wake_req();
        test_idle_interrupt();
        test_allow_drop();
        test_simultaneous();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
